// File: rtl/validador_pecas.sv
// Piece-placement validator: checks a requested piece against the player's board one cell
// per clock, then stores accepted pieces on command. `VALIDADOR_CONTADOR_EN adds per-player cell counters.
module validador_pecas #(
  parameter int LADO  = 8,
  parameter int N_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valida,
  input  logic       grava,
  input  logic       jogador,
  input  logic [2:0] tipo,
  input  logic [3:0] X1,
  input  logic [3:0] Y1,
  input  logic       direcao,
  input  logic [2:0] orientacao,
  output logic       conflito,
  output logic       done,
  output logic       gravado,
  output logic       busy,
  input  logic       rd_jogador,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic       rd_ocupado
`ifdef VALIDADOR_CONTADOR_EN
  ,
  output logic [6:0] celulas_j0,
  output logic [6:0] celulas_j1,
  output logic [1:0] frota_completa
`endif
);

  localparam int NB = LADO * LADO;
  localparam int BW = $clog2(NB);
  localparam int IW = $clog2(N_MAX);
  localparam logic signed [4:0] LADO_S = 5'(LADO);
  localparam logic [3:0]        LADO_U = 4'(LADO);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_RESULT, ST_WRITE} state_t;

  state_t state, state_n;

  logic          valida_q;
  logic          jog_l, dir_l;
  logic [2:0]    tipo_l, ori_l;
  logic [3:0]    x_l, y_l;
  logic [IW-1:0] idx, idx_n, n_last;
  logic          conf_ck, conf_ck_n;
  logic          pendente, pendente_n;
  logic          conflito_n, done_n, gravado_n;
  logic          latch, wr;
  logic [1:0][NB-1:0] boards;

  logic signed [4:0] dx, dy, cx, cy;
  logic [1:0]        ori_eff;
  logic              in_range, occ, bad;
  logic [BW-1:0]     cell_bit;

  logic              rd_in;
  logic [BW-1:0]     rd_bit;

  // Offset of cell idx relative to the anchor for the latched piece.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dx      = '0;
    dy      = '0;
    ori_eff = ori_l[2] ? 2'd0 : ori_l[1:0];
    if (tipo_l == 3'd2) begin
      if (idx == IW'(1)) begin
        dx = (ori_eff == 2'd3) ? -5'sd1 : 5'sd1;
        dy = (ori_eff == 2'd1) ? -5'sd1 : 5'sd1;
      end else if (idx == IW'(2)) begin
        if (ori_eff[1]) dy = 5'sd2;
        else            dx = 5'sd2;
      end
    end else if (dir_l) begin
      dy = 5'(idx);
    end else begin
      dx = 5'(idx);
    end
  end

  assign cx       = $signed({1'b0, x_l}) + dx;
  assign cy       = $signed({1'b0, y_l}) + dy;
  assign in_range = (cx >= 5'sd1) && (cx <= LADO_S) && (cy >= 5'sd1) && (cy <= LADO_S);
  assign cell_bit = BW'((32'(cy[3:0]) - 32'd1) * 32'(LADO) + (32'(cx[3:0]) - 32'd1));
  assign occ      = boards[jog_l][cell_bit];
  assign bad      = (tipo_l > 3'd4) || !in_range || occ;
  assign n_last   = IW'(tipo_l);

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    conf_ck_n  = conf_ck;
    pendente_n = pendente;
    conflito_n = conflito;
    done_n     = 1'b0;
    gravado_n  = 1'b0;
    latch      = 1'b0;
    wr         = 1'b0;
    case (state)
      ST_IDLE: begin
        // A store beats a simultaneous request edge; that edge is simply lost.
        if (grava && pendente) begin
          state_n = ST_WRITE;
          idx_n   = '0;
        end else if (valida && !valida_q) begin
          latch      = 1'b1;
          pendente_n = 1'b0;
          idx_n      = '0;
          state_n    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad) begin
          conf_ck_n = 1'b1;
          state_n   = ST_RESULT;
        end else if (idx == n_last) begin
          conf_ck_n = 1'b0;
          state_n   = ST_RESULT;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      ST_RESULT: begin
        conflito_n = conf_ck;
        done_n     = 1'b1;
        pendente_n = !conf_ck;
        state_n    = ST_IDLE;
      end
      ST_WRITE: begin
        wr = 1'b1;
        if (idx == n_last) begin
          gravado_n  = 1'b1;
          pendente_n = 1'b0;
          state_n    = ST_IDLE;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      valida_q <= 1'b0;
      jog_l    <= 1'b0;
      dir_l    <= 1'b0;
      tipo_l   <= '0;
      ori_l    <= '0;
      x_l      <= '0;
      y_l      <= '0;
      idx      <= '0;
      conf_ck  <= 1'b0;
      pendente <= 1'b0;
      conflito <= 1'b0;
      done     <= 1'b0;
      gravado  <= 1'b0;
      // NOTE: the boards are plain flops, not a RAM, so clearing them on reset is cheap and
      // guarantees an aborted write leaves nothing behind.
      boards   <= '0;
    end else begin
      state    <= state_n;
      valida_q <= valida;
      idx      <= idx_n;
      conf_ck  <= conf_ck_n;
      pendente <= pendente_n;
      conflito <= conflito_n;
      done     <= done_n;
      gravado  <= gravado_n;
      if (latch) begin
        jog_l  <= jogador;
        dir_l  <= direcao;
        tipo_l <= tipo;
        ori_l  <= orientacao;
        x_l    <= X1;
        y_l    <= Y1;
      end
      if (wr) boards[jog_l][cell_bit] <= 1'b1;
    end
  end

  assign busy = (state == ST_CHECK) || (state == ST_WRITE);

  assign rd_in      = (rd_x >= 4'd1) && (rd_x <= LADO_U) && (rd_y >= 4'd1) && (rd_y <= LADO_U);
  assign rd_bit     = BW'((32'(rd_y) - 32'd1) * 32'(LADO) + (32'(rd_x) - 32'd1));
  assign rd_ocupado = rd_in & boards[rd_jogador][rd_bit];

`ifdef VALIDADOR_CONTADOR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      celulas_j0 <= '0;
      celulas_j1 <= '0;
    end else if (wr) begin
      if (jog_l) celulas_j1 <= celulas_j1 + 7'd1;
      else       celulas_j0 <= celulas_j0 + 7'd1;
    end
  end

  // A full fleet is 5 submarines, 2 cruisers, 2 seaplanes, 1 battleship, 1 carrier = 24 cells.
  assign frota_completa = {celulas_j1 == 7'd24, celulas_j0 == 7'd24};
`endif

endmodule

// File: tb/tb_validador_pecas.sv
// Scoreboard bench for validador_pecas: stimulus pushes expected done/gravado events computed by
// a cell-list board model; a negedge monitor pops and compares them.
module tb_validador_pecas;

  logic       clk, reset;
  logic       valida, grava, jogador, direcao;
  logic [2:0] tipo, orientacao;
  logic [3:0] X1, Y1;
  logic       conflito, done, gravado, busy;
  logic       rd_jogador;
  logic [3:0] rd_x, rd_y;
  logic       rd_ocupado;
`ifdef VALIDADOR_CONTADOR_EN
  logic [6:0] celulas_j0, celulas_j1;
  logic [1:0] frota_completa;
`endif

  validador_pecas dut (
    .clk(clk), .reset(reset), .valida(valida), .grava(grava), .jogador(jogador),
    .tipo(tipo), .X1(X1), .Y1(Y1), .direcao(direcao), .orientacao(orientacao),
    .conflito(conflito), .done(done), .gravado(gravado), .busy(busy),
    .rd_jogador(rd_jogador), .rd_x(rd_x), .rd_y(rd_y), .rd_ocupado(rd_ocupado)
`ifdef VALIDADOR_CONTADOR_EN
    , .celulas_j0(celulas_j0), .celulas_j1(celulas_j1), .frota_completa(frota_completa)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_wr;
    bit conf;
    int due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: boards, pending accepted piece, per-player stored cell counts.
  bit mb [2][10][10];
  bit m_pend;
  int m_pj, m_n;
  int px[$], py[$];
  int m_cnt [2];
  bit last_conf;

  int hx [4][3] = '{'{0, 1, 2}, '{0, 1, 2}, '{0, 1, 0}, '{0, -1, 0}};
  int hy [4][3] = '{'{0, 1, 0}, '{0, -1, 0}, '{0, 1, 2}, '{0, 1, 2}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (reset && (done || gravado)) begin
      if (sbq.size() == 0) begin
        check("spurious_pulse", {30'd0, done, gravado}, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("resp_kind", gravado, e.is_wr);
        check("resp_cycle", cyc, e.due);
        if (!e.is_wr) check("conflito", conflito, e.conf);
      end
    end
  end

  function automatic void cell_off(input int t, input int d, input int o, input int i,
                                   output int dx, output int dy);
    int oe;
    oe = (o > 3) ? 0 : o;
    if (t == 2) begin
      dx = hx[oe][i];
      dy = hy[oe][i];
    end else begin
      dx = d ? 0 : i;
      dy = d ? i : 0;
    end
  endfunction

  task automatic clear_model();
    for (int j = 0; j < 2; j++)
      for (int x = 0; x < 10; x++)
        for (int y = 0; y < 10; y++) mb[j][x][y] = 1'b0;
    m_pend = 1'b0;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic rd_check(input string name, input int j, input int x, input int y, input bit exp);
    rd_jogador = j[0];
    rd_x = 4'(x);
    rd_y = 4'(y);
    #1;
    check(name, rd_ocupado, exp);
  endtask

  task automatic check_boards();
    for (int j = 0; j < 2; j++)
      for (int x = 0; x < 10; x++)
        for (int y = 0; y < 10; y++)
          rd_check("board", j, x, y,
                   (x >= 1 && x <= 8 && y >= 1 && y <= 8) ? mb[j][x][y] : 1'b0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (sbq.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      check("response_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  task automatic do_check(input int j, input int t, input int x, input int y,
                          input int d, input int o, input bit hold);
    int n, k, dx, dy, cx, cy;
    bit conf;
    tick();
    px.delete();
    py.delete();
    n = (t <= 4) ? t + 1 : 1;
    conf = 1'b0;
    k = 0;
    if (t > 4) begin
      conf = 1'b1;
      k = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        cell_off(t, d, o, i, dx, dy);
        cx = x + dx;
        cy = y + dy;
        k = i + 1;
        if (cx < 1 || cx > 8 || cy < 1 || cy > 8 || mb[j][cx][cy]) begin
          conf = 1'b1;
          break;
        end
        px.push_back(cx);
        py.push_back(cy);
      end
    end
    m_pend = !conf;
    m_pj = j;
    m_n = n;
    last_conf = conf;
    sbq.push_back('{1'b0, conf, cyc + 1 + k + 1});
    jogador = j[0];
    tipo = 3'(t);
    X1 = 4'(x);
    Y1 = 4'(y);
    direcao = d[0];
    orientacao = 3'(o);
    valida = 1'b1;
    tick();
    check("busy_in_check", busy, 1'b1);
    if (!hold) valida = 1'b0;
    jogador = 1'($urandom);
    tipo = 3'($urandom);
    X1 = 4'($urandom);
    Y1 = 4'($urandom);
    direcao = 1'($urandom);
    orientacao = 3'($urandom);
    wait_idle();
  endtask

  task automatic commit_model();
    for (int i = 0; i < px.size(); i++) mb[m_pj][px[i]][py[i]] = 1'b1;
    m_cnt[m_pj] += px.size();
    m_pend = 1'b0;
  endtask

  task automatic do_store();
    tick();
    if (m_pend) begin
      sbq.push_back('{1'b1, 1'b0, cyc + 1 + m_n});
      grava = 1'b1;
      tick();
      grava = 1'b0;
      wait_idle();
      commit_model();
    end else begin
      grava = 1'b1;
      repeat (4) tick();
      check("grava_ignored_busy", busy, 1'b0);
      grava = 1'b0;
      repeat (8) tick();
    end
  endtask

  task automatic apply_reset();
    sbq.delete();
    reset = 1'b0;
    valida = 1'b0;
    grava = 1'b0;
    #1;
    clear_model();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_gravado", gravado, 1'b0);
    check("rst_conflito", conflito, 1'b0);
    check_boards();
    tick();
    reset = 1'b1;
    tick();
  endtask

`ifdef VALIDADOR_CONTADOR_EN
  int fleet [11][5] = '{'{0, 1, 1, 0, 0}, '{0, 3, 1, 0, 0}, '{0, 5, 1, 0, 0}, '{0, 7, 1, 0, 0},
                        '{0, 1, 3, 0, 0}, '{1, 3, 3, 0, 0}, '{1, 6, 3, 0, 0}, '{2, 1, 5, 0, 0},
                        '{2, 5, 5, 0, 0}, '{3, 1, 8, 0, 0}, '{4, 8, 2, 1, 0}};
`endif

  initial begin
    reset = 1'b0; valida = 1'b0; grava = 1'b0; jogador = 1'b0; tipo = '0;
    X1 = '0; Y1 = '0; direcao = 1'b0; orientacao = '0;
    rd_jogador = 1'b0; rd_x = '0; rd_y = '0;
    apply_reset();

    // Carrier accepted and stored, then probed through the read port.
    do_check(0, 4, 2, 3, 0, 0, 1'b0);
    do_store();
    rd_check("rd_p0_4_3", 0, 4, 3, 1'b1);
    rd_check("rd_p1_4_3", 1, 4, 3, 1'b0);
    rd_check("rd_p0_7_3", 0, 7, 3, 1'b0);

    // Overlap abort; the following store must be ignored.
    do_check(0, 1, 4, 2, 1, 0, 1'b0);
    do_store();
    rd_check("rd_p0_4_2", 0, 4, 2, 1'b0);

    do_check(0, 3, 6, 1, 0, 0, 1'b0);
    do_check(0, 0, 0, 5, 0, 0, 1'b0);
    do_check(0, 2, 1, 5, 0, 3, 1'b0);
    do_check(0, 2, 1, 5, 0, 7, 1'b0);
    do_store();
    rd_check("rd_hidro_2_6", 0, 2, 6, 1'b1);
    rd_check("rd_hidro_1_6", 0, 1, 6, 1'b0);
    do_check(0, 6, 7, 7, 0, 0, 1'b0);

    // valida held high across two requests: only the first check runs.
    do_check(1, 0, 1, 1, 0, 0, 1'b1);
    jogador = 1'b1; tipo = 3'd1; X1 = 4'd3; Y1 = 4'd3; direcao = 1'b0;
    repeat (10) tick();
    valida = 1'b0;
    tick();

    // valida edge coincident with grava while a piece is pending: the store wins.
    if (m_pend) begin
      sbq.push_back('{1'b1, 1'b0, cyc + 1 + m_n});
      jogador = 1'b0; tipo = 3'd0; X1 = 4'd8; Y1 = 4'd8;
      valida = 1'b1;
      grava = 1'b1;
      tick();
      valida = 1'b0;
      grava = 1'b0;
      wait_idle();
      commit_model();
      repeat (8) tick();
    end
    check_boards();

    for (int i = 0; i < 40; i++) begin
      int t;
      t = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
      do_check($urandom_range(0, 1), t, $urandom_range(0, 9), $urandom_range(0, 9),
               $urandom_range(0, 1), $urandom_range(0, 7), 1'b0);
      if ($urandom_range(0, 2) != 0) do_store();
    end
    repeat (3) tick();
    check("conflito_hold", conflito, last_conf);
    check_boards();

    // Reset during a carrier write after two of its five cells.
    apply_reset();
    do_check(0, 4, 1, 1, 0, 0, 1'b0);
    tick();
    grava = 1'b1;
    tick();
    grava = 1'b0;
    tick();
    tick();
    rd_check("mid_write_c0", 0, 1, 1, 1'b1);
    rd_check("mid_write_c1", 0, 2, 1, 1'b1);
    rd_check("mid_write_c2", 0, 3, 1, 1'b0);
    check("mid_write_busy", busy, 1'b1);
    apply_reset();

`ifdef VALIDADOR_CONTADOR_EN
    for (int i = 0; i < 11; i++) begin
      do_check(1, fleet[i][0], fleet[i][1], fleet[i][2], fleet[i][3], fleet[i][4], 1'b0);
      do_store();
    end
    tick();
    check("celulas_j1", celulas_j1, m_cnt[1]);
    check("celulas_j0", celulas_j0, m_cnt[0]);
    check("fleet_cells", celulas_j1, 32'd24);
    check("frota_completa", frota_completa, {30'd0, m_cnt[1] == 24, m_cnt[0] == 24});
    check_boards();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
